rf_dump: RTL
============

// Module: rf_dump
// PURPOSE
//  Debug reader for the register file: on a start pulse, walks every register through the RF
//  read port, captures each value and streams it as bytes over a valid/ready byte interface
//  (feeds the UART TX on the ULX3S). Frame = header 0xA5, per-register bytes LSB-first, XOR checksum.
//  Sits beside the core; drives the RF rs address and consumes the combinational read data.
// PARAMETERS
//  NUM_REGS  32  number of registers dumped, indices 0..NUM_REGS-1 (>=2)
//  DATA_W    32  register width, equals width of data_t; multiple of 8. BYTES = DATA_W/8 (derived)
// PORTS
//  clk       in   1                    clock, all state on rising edge
//  reset_n   in   1                    asynchronous, active-low reset
//  start     in   1                    request a dump; sampled only in IDLE
//  busy      out  1                    high in every state except IDLE
//  done      out  1                    one-cycle pulse after checksum byte accepted
//  rd_addr   out  $clog2(NUM_REGS)     RF read address (to rs1/rs2 of RF)
//  rd_data   in   DATA_W (data_t)      RF read data, combinational from rd_addr
//  tx_data   out  8                    stream byte; 0 when tx_valid low
//  tx_valid  out  1                    byte valid
//  tx_ready  in   1                    sink accepts byte; handshake = tx_valid & tx_ready at edge
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, busy=0, done=0, tx_valid=0, tx_data=0, rd_addr=0,
//   idx=0, byte_cnt=0, csum=0, shift reg=0. Abort any frame; no resume after release.
//  States: IDLE, HDR, LOAD, SEND, CSUM, DONE (all registered; outputs decoded from state/regs).
//  IDLE: start=1 -> HDR; idx<=0, csum<=0. start=0 -> stay.
//  HDR : tx_valid=1, tx_data=8'hA5; handshake -> LOAD. Header not in checksum.
//  LOAD: tx_valid=0; rd_addr=idx (already stable); shreg<=rd_data, byte_cnt<=0 -> SEND.
//  SEND: tx_valid=1, tx_data=shreg[7:0]; on handshake csum<=csum^shreg[7:0], shreg>>=8,
//   byte_cnt++; if byte_cnt==BYTES-1: idx==NUM_REGS-1 -> CSUM, else idx<=idx+1 -> LOAD.
//  CSUM: tx_valid=1, tx_data=csum; handshake -> DONE.
//  DONE: done=1, busy=1, tx_valid=0; -> IDLE unconditionally.
//  rd_addr = idx register at all times; changes only on SEND->LOAD transition or start.
//  Stream rules: once tx_valid=1, tx_valid and tx_data hold until handshake; no combinational
//   path tx_ready -> tx_valid/tx_data. tx_ready ignored when tx_valid=0.
//  start ignored in every non-IDLE state, including DONE; start held high -> new frame begins
//   after one IDLE cycle.
//  Consistency: each register sampled at its own LOAD cycle; RF writes during dump are
//   visible if they land before that register's LOAD. No atomic snapshot.
//  Latency, tx_ready=1: start sampled at edge N -> HDR cycle N+1, done high in cycle
//   N+3+NUM_REGS*(1+BYTES); frame = 2+NUM_REGS*BYTES bytes (defaults: done at N+163, 130 bytes).
//  idx/byte_cnt never wrap: terminal compare ends the walk exactly at NUM_REGS-1 / BYTES-1.
// TESTING
//  1 reset_n=0 mid-idle and mid-frame -> busy,done,tx_valid,tx_data,rd_addr all 0 immediately.
//  2 RF all 0 except reg1=32'hDEADBEEF, tx_ready=1, start pulse -> A5, 00x4, EF BE AD DE,
//    00x120, csum 8'h22; 130 bytes; done single pulse at N+163; rd_addr steps 0..31.
//  3 Same data, tx_ready random 50% plus 10-cycle low stall in SEND -> identical byte stream,
//    tx_data/tx_valid stable on every stalled cycle, no dropped or repeated byte.
//  4 start pulses during HDR, SEND and DONE -> ignored, exactly one frame; start held high ->
//    back-to-back frames separated by exactly one IDLE cycle.
//  5 RF write to reg5 while idx=3, and to reg2 while idx=3 -> frame shows new reg5, old reg2.
//  6 NUM_REGS=4, DATA_W=16, regs={16'h0001,16'h0200,16'h0000,16'h8000}, tx_ready=1 ->
//    A5 01 00 00 02 00 00 00 80 csum 8'h83; 10 bytes; done at N+15.

Source files
------------

// File: rtl/rf_dump.sv
// Register-file dump engine: walks every RF entry through the read port and streams
// a framed byte sequence (0xA5 header, registers LSB-first, XOR checksum) over valid/ready.
module rf_dump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  localparam int BYTES   = DATA_W / 8,
  localparam int IDX_W   = $clog2(NUM_REGS),
  localparam int CNT_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  // state | meaning
  // IDLE  | waiting for start
  // HDR   | presenting header byte 0xA5
  // LOAD  | capturing rd_data for register idx into the shift register
  // SEND  | presenting shreg[7:0], one byte per handshake
  // CSUM  | presenting XOR checksum of all register bytes
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_SEND,
    S_CSUM,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      shreg_q <= shreg_d;
    end
  end

  // Outputs decode only registered state, so tx_ready never reaches tx_valid/tx_data.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    shreg_d  = shreg_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_ready) state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d = rd_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[7:0];
        if (tx_ready) begin
          csum_d  = csum_q ^ shreg_q[7:0];
          shreg_d = shreg_q >> 8;
          if (cnt_q == CNT_LAST) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_CSUM;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_LOAD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr = idx_q;

endmodule
